// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Memory handshake bundle between the multi-cycle control FSM and the
// instruction/data memories.
//   imem_req    controller -> imem   instruction fetch request
//   imem_valid  imem -> controller   fetch data valid
//   dmem_req    controller -> dmem   data access request
//   dmem_we     controller -> dmem   1 = store, 0 = load (qualified by dmem_req)
//   dmem_valid  dmem -> controller   data access complete
// master: the controller side; slave: the memory side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_valid;
    logic dmem_req;
    logic dmem_we;
    logic dmem_valid;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_valid,
        input  dmem_valid
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_valid,
        output dmem_valid
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multi-cycle RV32I core. Walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB, drives all datapath strobes and
// mux selects, runs the imem/dmem handshakes, counts retired instructions
// and parks in HALT on a fault.
// Ports:
//   clock, reset   core clock; synchronous active-high reset
//   opcode,funct3  IR fields, valid from DECODE onward
//   br_taken       branch comparator result, used in EXEC
//   mem            memory handshake bundle (master side)
//   ir_we, pc_we, rf_we            datapath write strobes
//   pc_sel, wb_sel, alu_a_sel, alu_b_sel   datapath mux selects
//   state          current FSM state encoding
//   fault_code     0 none, 1 illegal, 2 dmem timeout, 3 ECALL/EBREAK
//   instret        retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 br_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic [2:0]           state,
    output logic [1:0]           fault_code,
    output logic [CNT_W-1:0]     instret
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR,
        CL_LUI, CL_AUIPC, CL_FENCE, CL_SYSTEM, CL_ILLEGAL
    } class_t;

    state_t              state_q, state_d;
    class_t              class_q, class_d;
    logic [1:0]          fault_q, fault_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    instret_q;
    logic                retire;
    logic                cls_a_sel, cls_b_sel;

    // Instruction class from the raw IR fields; only captured in DECODE.
    always_comb begin
        class_d = CL_ILLEGAL;
        case (opcode)
            7'b0110011: class_d = CL_OP;
            7'b0010011: class_d = CL_OPIMM;
            7'b0000011: class_d = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
                                  ? CL_ILLEGAL : CL_LOAD;
            7'b0100011: class_d = (funct3 > 3'd2) ? CL_ILLEGAL : CL_STORE;
            7'b1100011: class_d = CL_BRANCH;
            7'b1101111: class_d = CL_JAL;
            7'b1100111: class_d = CL_JALR;
            7'b0110111: class_d = CL_LUI;
            7'b0010111: class_d = CL_AUIPC;
            7'b0001111: class_d = CL_FENCE;
            7'b1110011: class_d = CL_SYSTEM;
            default:    class_d = CL_ILLEGAL;
        endcase
    end

    // State, latched class, fault, dmem wait counter and retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            class_q   <= CL_OP;
            fault_q   <= 2'd0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
            if (state_q == S_DECODE) begin
                class_q <= class_d;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic. The wait counter only runs in MEM and is cleared
    // everywhere else, so each memory access starts its budget from zero.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        wait_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (mem.imem_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (class_d)
                    CL_ILLEGAL: begin
                        state_d = S_HALT;
                        fault_d = 2'd1;
                    end
                    CL_SYSTEM: begin
                        state_d = S_HALT;
                        fault_d = 2'd3;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (class_q)
                    CL_BRANCH:         state_d = S_FETCH;
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem.dmem_valid) begin
                    state_d = (class_q == CL_STORE) ? S_FETCH : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 2'd2;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    // ALU operand selects implied by the latched class.
    always_comb begin
        cls_a_sel = 1'b0;
        cls_b_sel = 1'b0;
        case (class_q)
            CL_OP: begin
                cls_a_sel = 1'b0;
                cls_b_sel = 1'b0;
            end
            CL_OPIMM, CL_LOAD, CL_STORE, CL_JALR: begin
                cls_a_sel = 1'b0;
                cls_b_sel = 1'b1;
            end
            CL_AUIPC, CL_JAL, CL_BRANCH: begin
                cls_a_sel = 1'b1;
                cls_b_sel = 1'b1;
            end
            default: begin
                cls_a_sel = 1'b0;
                cls_b_sel = 1'b0;
            end
        endcase
    end

    // Output decode from state and class. Everything is forced low while
    // reset is asserted so that a reset landing mid-instruction never lets
    // a write strobe or memory request escape in the reset cycle.
    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        retire       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem.imem_req = 1'b1;
                    ir_we        = mem.imem_valid;
                end
                S_EXEC: begin
                    alu_a_sel = cls_a_sel;
                    alu_b_sel = cls_b_sel;
                    if (class_q == CL_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? 2'd1 : 2'd0;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    alu_a_sel    = cls_a_sel;
                    alu_b_sel    = cls_b_sel;
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = (class_q == CL_STORE);
                    if (mem.dmem_valid && class_q == CL_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    alu_a_sel = cls_a_sel;
                    alu_b_sel = cls_b_sel;
                    rf_we     = 1'b1;
                    pc_we     = 1'b1;
                    retire    = 1'b1;
                    case (class_q)
                        CL_LOAD: wb_sel = 2'd1;
                        CL_LUI:  wb_sel = 2'd3;
                        CL_JAL: begin
                            wb_sel = 2'd2;
                            pc_sel = 2'd1;
                        end
                        CL_JALR: begin
                            wb_sel = 2'd2;
                            pc_sel = 2'd2;
                        end
                        default: wb_sel = 2'd0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign fault_code = fault_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed testbench for multicycle_ctrl. Inputs are driven just after the
// falling edge, outputs are sampled 1 time unit later, well away from the
// rising edge that advances the FSM.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_taken;
    logic        ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel;
    logic [1:0]  pc_sel, wb_sel, fault_code;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;

    multicycle_ctrl_if mem_bus ();

    multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .br_taken   (br_taken),
        .mem        (mem_bus.master),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .state      (state),
        .fault_code (fault_code),
        .instret    (instret)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive the memory/branch inputs for this cycle and let them settle.
    task automatic applyStimulus(input logic iv, input logic dv, input logic bt);
        mem_bus.imem_valid = iv;
        mem_bus.dmem_valid = dv;
        br_taken           = bt;
        #1;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", state, 3'd0);
        checkOutput("rst_instret", instret, 0);
        checkOutput("rst_fault", fault_code, 2'd0);
        checkOutput("rst_imem_req", mem_bus.imem_req, 1'b0);
        tick();
        reset = 1'b0;
        exp_instret = 0;
    endtask

    // One FETCH cycle with imem_valid, then the DECODE cycle.
    task automatic fetchInstr(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("fetch_state", state, 3'd0);
        checkOutput("fetch_instret", instret, exp_instret);
        checkOutput("fetch_imem_req", mem_bus.imem_req, 1'b1);
        checkOutput("fetch_ir_we", ir_we, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("decode_state", state, 3'd1);
        checkOutput("decode_imem_req", mem_bus.imem_req, 1'b0);
        tick();
    endtask

    // Register-writing, non-memory, non-branch instruction: EXEC then WB.
    task automatic runReg(input string tag, input logic [6:0] op, input logic chk_sel,
                          input logic a, input logic b, input logic [1:0] wb, input logic [1:0] ps);
        fetchInstr(op, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_exec_state"}, state, 3'd2);
        if (chk_sel) begin
            checkOutput({tag, "_alu_a"}, alu_a_sel, a);
            checkOutput({tag, "_alu_b"}, alu_b_sel, b);
        end
        checkOutput({tag, "_exec_writes"}, {pc_we, rf_we}, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_wb_state"}, state, 3'd4);
        checkOutput({tag, "_wb_writes"}, {pc_we, rf_we}, 2'b11);
        checkOutput({tag, "_wb_sel"}, wb_sel, wb);
        checkOutput({tag, "_pc_sel"}, pc_sel, ps);
        tick();
        exp_instret++;
    endtask

    task automatic runBranch(input logic taken);
        fetchInstr(OP_BR, 3'd0);
        applyStimulus(1'b0, 1'b0, taken);
        checkOutput("br_state", state, 3'd2);
        checkOutput("br_pc_we", pc_we, 1'b1);
        checkOutput("br_pc_sel", pc_sel, taken ? 2'd1 : 2'd0);
        checkOutput("br_rf_we", rf_we, 1'b0);
        checkOutput("br_alu_sel", {alu_a_sel, alu_b_sel}, 2'b11);
        tick();
        exp_instret++;
    endtask

    // Load or store with a number of dmem wait cycles before valid.
    task automatic runMem(input logic store, input int waits);
        fetchInstr(store ? OP_STORE : OP_LOAD, 3'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ls_exec_state", state, 3'd2);
        checkOutput("ls_alu_sel", {alu_a_sel, alu_b_sel}, 2'b01);
        tick();
        for (int i = 0; i < waits; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("ls_wait_state", state, 3'd3);
            checkOutput("ls_wait_req", {mem_bus.dmem_req, mem_bus.dmem_we}, {1'b1, store});
            checkOutput("ls_wait_writes", {pc_we, rf_we}, 2'b00);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ls_done_req", {mem_bus.dmem_req, mem_bus.dmem_we}, {1'b1, store});
        checkOutput("ls_done_writes", {pc_we, rf_we}, {store, 1'b0});
        checkOutput("ls_done_pc_sel", pc_sel, 2'd0);
        tick();
        if (!store) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("ld_wb_state", state, 3'd4);
            checkOutput("ld_wb_writes", {pc_we, rf_we}, 2'b11);
            checkOutput("ld_wb_sel", wb_sel, 2'd1);
            checkOutput("ld_pc_sel", pc_sel, 2'd0);
            checkOutput("ld_dmem_req", mem_bus.dmem_req, 1'b0);
            tick();
        end
        exp_instret++;
    endtask

    initial begin
        opcode   = 7'd0;
        funct3   = 3'd0;
        mem_bus.imem_valid = 1'b0;
        mem_bus.dmem_valid = 1'b0;
        br_taken = 1'b0;
        doReset();

        // First post-reset cycle: FETCH requests but nothing is valid yet.
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_state", state, 3'd0);
        checkOutput("post_rst_imem_req", mem_bus.imem_req, 1'b1);
        checkOutput("post_rst_ir_we", ir_we, 1'b0);
        tick();

        runReg("addi", OP_ADDI, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
        runReg("auipc", OP_AUIPC, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
        runBranch(1'b1);
        runBranch(1'b0);
        runMem(1'b0, 3);
        runMem(1'b1, 1);

        // dmem_valid while in FETCH must not move the FSM.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stray_dv_state", state, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stray_dv_state2", state, 3'd0);
        checkOutput("stray_dv_instret", instret, exp_instret);
        tick();

        runReg("lui", OP_LUI, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0);
        runReg("jalr", OP_JALR, 1'b1, 1'b0, 1'b1, 2'd2, 2'd2);

        // Reset landing in MEM of a store.
        fetchInstr(OP_STORE, 3'd2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midrst_state", state, 3'd3);
        checkOutput("midrst_dmem_req", mem_bus.dmem_req, 1'b0);
        checkOutput("midrst_writes", {pc_we, rf_we}, 2'b00);
        tick();
        reset = 1'b0;
        exp_instret = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("after_rst_state", state, 3'd0);
        checkOutput("after_rst_dmem_req", mem_bus.dmem_req, 1'b0);
        checkOutput("after_rst_instret", instret, 0);
        checkOutput("after_rst_imem_req", mem_bus.imem_req, 1'b1);
        tick();
        runReg("jal", OP_JAL, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1);

        // Store that never completes: 8 MEM cycles then HALT with fault 2.
        fetchInstr(OP_STORE, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("tmo_wait_state", state, 3'd3);
            checkOutput("tmo_wait_req", mem_bus.dmem_req, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("tmo_state", state, 3'd5);
        checkOutput("tmo_fault", fault_code, 2'd2);
        checkOutput("tmo_dmem_req", mem_bus.dmem_req, 1'b0);
        checkOutput("tmo_instret", instret, exp_instret);
        tick();

        // Illegal opcode: HALT with fault 1, deaf to imem_valid.
        doReset();
        fetchInstr(7'b0000000, 3'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(logic'(i % 2), 1'b0, 1'b0);
            checkOutput("ill_imem_req", mem_bus.imem_req, 1'b0);
            checkOutput("ill_ir_we", ir_we, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ill_state", state, 3'd5);
        checkOutput("ill_fault", fault_code, 2'd1);
        checkOutput("ill_instret", instret, 0);
        tick();

        // Load with a reserved funct3 is illegal too.
        doReset();
        fetchInstr(OP_LOAD, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ill_ld_state", state, 3'd5);
        checkOutput("ill_ld_fault", fault_code, 2'd1);
        tick();

        // Store with funct3 above word is illegal.
        doReset();
        fetchInstr(OP_STORE, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ill_st_state", state, 3'd5);
        checkOutput("ill_st_fault", fault_code, 2'd1);
        tick();

        // ECALL/EBREAK stops the core with fault 3.
        doReset();
        fetchInstr(OP_SYS, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("sys_state", state, 3'd5);
        checkOutput("sys_fault", fault_code, 2'd3);
        checkOutput("sys_writes", {pc_we, rf_we, ir_we}, 3'b000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
